// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall detection over FWD_DEPTH in-flight stages.
// Optional HAZARD_PERF_EN adds a saturating load-use stall cycle counter (stallCount).
module forward_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issueValid,
    input  logic [REG_ADDR_W-1:0]         issueRd,
    input  logic                          issueWritesRd,
    input  logic                          issueIsLoad,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddr,
    input  logic [NUM_SRC-1:0]            srcUsed,
    input  logic                          flush,
    input  logic                          stallExt,
    output logic [NUM_SRC*SEL_W-1:0]      fwdSel,
    output logic                          stallD
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                   stallCount
`endif
);

    logic                  ent_valid   [1:FWD_DEPTH];
    logic [REG_ADDR_W-1:0] ent_rd      [1:FWD_DEPTH];
    logic                  ent_load    [1:FWD_DEPTH];
    logic                  ent_writing [1:FWD_DEPTH];

    logic [NUM_SRC-1:0]    src_stall;
    logic [SEL_W-1:0]      sel;
    logic                  hit_early_load;
    logic                  issue_accept;

    // x0 is hardwired, so an entry targeting it never forwards
    always_comb begin
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            ent_writing[k] = ent_valid[k] && (ent_rd[k] != '0);
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        fwdSel         = '0;
        src_stall      = '0;
        sel            = '0;
        hit_early_load = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel            = '0;
            hit_early_load = 1'b0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (srcUsed[i] && ent_writing[k] &&
                    (ent_rd[k] == srcAddr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    sel            = SEL_W'(k);
                    hit_early_load = ent_load[k] && (k < 1 + LOAD_LAT);
                end
            end
            fwdSel[i*SEL_W +: SEL_W] = sel;
            src_stall[i]             = hit_early_load;
        end
    end

    assign stallD       = issueValid && (|src_stall);
    assign issue_accept = issueValid && issueWritesRd && !stallD && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                ent_valid[k] <= 1'b0;
                ent_rd[k]    <= '0;
                ent_load[k]  <= 1'b0;
            end
        end else if (!stallExt) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_rd[k]    <= ent_rd[k-1];
                ent_load[k]  <= ent_load[k-1];
            end
            ent_valid[1] <= issue_accept;
            ent_rd[1]    <= issueRd;
            ent_load[1]  <= issueIsLoad;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
        end else if (stallD && !stallExt && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined core. It tracks the destination register of every in-flight instruction across `FWD_DEPTH` post-issue stages. For each of `NUM_SRC` source operands of the issuing instruction it produces a forward-select code, and it asserts a decode stall when a source depends on a load whose data is not yet available. It generalises the fixed two-source, three-level `rs1ForwardSrc`/`rs2ForwardSrc` scheme to arbitrary source count, depth and load latency.

## Interface
Parameters:
- `NUM_SRC`, 2, number of source operands checked per issuing instruction (1–4).
- `REG_ADDR_W`, 5, register address width.
- `FWD_DEPTH`, 3, number of tracked post-issue stages. Stage k=1 is youngest (compute result), k=FWD_DEPTH is oldest (post-writeback).
- `LOAD_LAT`, 1, load data becomes forwardable from stage 1+LOAD_LAT onward. Range 0..FWD_DEPTH-1.
- `SEL_W`, $clog2(FWD_DEPTH+1), forward-select width (derived).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `issueValid`  in  1  an instruction is presented for issue this cycle.
- `issueRd`  in  REG_ADDR_W  destination register of the issuing instruction.
- `issueWritesRd`  in  1  the issuing instruction writes `issueRd`.
- `issueIsLoad`  in  1  the issuing instruction is a load.
- `srcAddr`  in  NUM_SRC×REG_ADDR_W  packed source register addresses.
- `srcUsed`  in  NUM_SRC  per-source read enable.
- `flush`  in  1  kill the issuing instruction.
- `stallExt`  in  1  global pipeline freeze, e.g. memory wait.
- `fwdSel`  out  NUM_SRC×SEL_W  per-source forward select. 0 = no forward (register file); k = data from stage k.
- `stallD`  out  1  load-use stall request to decode.
- `stallCount`  out  32  load-use stall cycle counter. Present only with `HAZARD_PERF_EN`.

## Operation
Tracking state:
- Shift register of `FWD_DEPTH` entries, each holding {valid, rd, isLoad}.
- An entry is "writing" iff valid and rd ≠ 0. Register x0 never matches.

Forward select, per source i with `srcUsed[i]`=1:
- Find the smallest k with a writing entry at stage k whose rd equals `srcAddr[i]`.
- `fwdSel[i]` = k. If no match, or `srcUsed[i]`=0, `fwdSel[i]` = 0.
- The youngest match always wins.

Load-use stall:
- `stallD` = `issueValid` AND (there exists i whose selected stage k holds a load with k < 1+LOAD_LAT).
- With LOAD_LAT=0, `stallD` is constant 0.
- When `stallD`=1, `fwdSel` is still driven as computed but is don't-care downstream.

State update each rising edge:
- If `stallExt`=1: hold all entries. `flush` and issue inputs are ignored.
- Else entries shift: stage k+1 ← stage k, and the oldest entry is discarded.
- Stage 1 ← {1, `issueRd`, `issueIsLoad`} if `issueValid` AND `issueWritesRd` AND NOT `stallD` AND NOT `flush`.
- Otherwise stage 1 ← bubble (valid=0).
- While stalled, the same instruction is re-presented on the next cycle. The inserted bubble advances the load, so the stall clears after exactly 1+LOAD_LAT−k cycles.

Reset:
- All entries invalid.
- `fwdSel` = 0 and `stallD` = 0 immediately (asynchronous).
- `stallCount` = 0.
- Reset assertion mid-stall drops the stall in the same cycle.

## Timing
- `fwdSel` and `stallD` are combinational from the current inputs and the registered entries. Zero-cycle latency, no registered outputs.
- Issue-to-tracking latency is one cycle: an instruction issued in cycle n is matchable at stage 1 in cycle n+1 and at stage k in cycle n+k, absent `stallExt`.
- Each `stallExt` cycle adds one cycle to every entry's residency.
- After cycle n+FWD_DEPTH the entry is gone. The register file must provide write-before-read for that point.
- Simultaneous `flush` and `stallD`: a bubble is inserted either way. `stallD` is still reported.

## Configuration
- `HAZARD_PERF_EN` defined: `stallCount` exists. It increments by 1 on each edge where `stallD`=1 AND `stallExt`=0, saturates at 32'hFFFF_FFFF, and is cleared only by reset.
- `HAZARD_PERF_EN` undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- **Basic forward:** issue `add x5` (writes), then next cycle issue with srcAddr[0]=5 → fwdSel[0]=1. Idle one cycle, then present the same source again → fwdSel[0]=2, then 3, then 0.
- **Youngest wins:** writers to x7 issued in consecutive cycles, then a read of x7 → fwdSel=1, not 2. A write to x0 followed by a read of x0 → fwdSel=0.
- **Load-use:** LOAD_LAT=1, `lw x3` issued, then a reader of x3 → stallD=1 for exactly 1 cycle. Next cycle → stallD=0, fwdSel=2. With `HAZARD_PERF_EN`, stallCount=1.
- **External freeze:** `stallExt`=1 for 3 cycles right after `lw x3` → entry held at stage 1, stallD stays 1 throughout, stallCount unchanged. It clears 1 cycle after stallExt drops.
- **Flush:** issue writer x9 with flush=1, then a reader of x9 → fwdSel=0 every cycle.
- **Reset:** async reset asserted mid-stall (stallD=1) → stallD=0 and fwdSel=0 without a clock edge. After release, a reader of x3 → fwdSel=0 and stallCount=0.
